// File: rtl/rv64_decode_exec_mem.sv
// Single-cycle RV64I decode/execute/data-memory stage: register file, ALU, next-PC and internal data RAM.
// Optional RV64M multiply/divide support is enabled by defining RV64M_EN.
module rv64_decode_exec_mem #(
    parameter logic [63:0] DMEM_BASE  = 64'h8000_0000,
    parameter int unsigned DMEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    input  logic [31:0] inst,
    output logic [63:0] nextpc,
    output logic [63:0] alu_result,
    output logic        ebreak,
    output logic        illegal,
    output logic        mem_fault,
    input  logic [4:0]  dbg_raddr,
    output logic [63:0] dbg_rdata
);

    localparam int unsigned IDXW       = $clog2(DMEM_WORDS);
    localparam logic [63:0] DMEM_BYTES = 64'(DMEM_WORDS) << 3;
    localparam logic [6:0]  OPC_LUI     = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  OPC_JALR    = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0]  OPC_OP      = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0]  OPC_OP32    = 7'b0111011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    logic [63:0] rf_q  [32];
    logic [63:0] mem_q [DMEM_WORDS];

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [63:0] rs1_val, rs2_val, pc4;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];
    assign imm_i  = {{52{inst[31]}}, inst[31:20]};
    assign imm_s  = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pc4    = pc + 64'd4;

    assign rs1_val   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val   = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf_q[dbg_raddr];

    // Base integer ALU; word mode truncates shamt to 5 bits and sign-extends the low word.
    function automatic logic [63:0] alu_f(input logic alt, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic word);
        logic [63:0]        r;
        logic [5:0]         sh;
        logic signed [63:0] sa;
        logic signed [31:0] sa32;
        sh   = word ? {1'b0, b[4:0]} : b[5:0];
        sa   = a;
        sa32 = a[31:0];
        r    = '0;
        case (op)
            3'b000: r = alt ? a - b : a + b;
            3'b001: r = a << sh;
            3'b010: r = {63'b0, $signed(a) < $signed(b)};
            3'b011: r = {63'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: begin
                if (word) begin
                    if (alt) r = {32'b0, sa32 >>> sh};
                    else     r = {32'b0, a[31:0] >> sh};
                end else begin
                    if (alt) r = sa >>> sh;
                    else     r = a >> sh;
                end
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

`ifdef RV64M_EN
    // Multiply/divide with RISC-V divide-by-zero and MIN/-1 overflow results.
    function automatic logic [63:0] mdu_f(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic word);
        logic [127:0]       p_ss, p_su, p_uu;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [63:0]        r;
        logic [31:0]        r32;
        p_ss = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        p_su = {{64{a[63]}}, a} * {64'b0, b};
        p_uu = {64'b0, a} * {64'b0, b};
        sa   = a;
        sb   = b;
        sa32 = a[31:0];
        sb32 = b[31:0];
        r    = '0;
        r32  = '0;
        if (!word) begin
            case (op)
                3'b000: r = p_uu[63:0];
                3'b001: r = p_ss[127:64];
                3'b010: r = p_su[127:64];
                3'b011: r = p_uu[127:64];
                3'b100: begin
                    if (b == 64'd0) r = '1;
                    else if (a == {1'b1, 63'b0} && b == '1) r = a;
                    else r = sa / sb;
                end
                3'b101: r = (b == 64'd0) ? '1 : a / b;
                3'b110: begin
                    if (b == 64'd0) r = a;
                    else if (a == {1'b1, 63'b0} && b == '1) r = '0;
                    else r = sa % sb;
                end
                default: r = (b == 64'd0) ? a : a % b;
            endcase
        end else begin
            case (op)
                3'b000: r32 = p_uu[31:0];
                3'b100: begin
                    if (b[31:0] == 32'd0) r32 = '1;
                    else if (a[31:0] == {1'b1, 31'b0} && b[31:0] == '1) r32 = a[31:0];
                    else r32 = sa32 / sb32;
                end
                3'b101: r32 = (b[31:0] == 32'd0) ? '1 : a[31:0] / b[31:0];
                3'b110: begin
                    if (b[31:0] == 32'd0) r32 = a[31:0];
                    else if (a[31:0] == {1'b1, 31'b0} && b[31:0] == '1) r32 = '0;
                    else r32 = sa32 % sb32;
                end
                default: r32 = (b[31:0] == 32'd0) ? a[31:0] : a[31:0] % b[31:0];
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction
`endif

    logic        legal, is_ebreak, is_load, is_store, rd_we;
    logic [63:0] res, npc;

    // Instruction decode, ALU select and next-PC.
    always_comb begin
        legal     = 1'b0;
        is_ebreak = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        rd_we     = 1'b0;
        res       = '0;
        npc       = pc4;
        case (opcode)
            OPC_LUI:   begin legal = 1'b1; rd_we = 1'b1; res = imm_u; end
            OPC_AUIPC: begin legal = 1'b1; rd_we = 1'b1; res = pc + imm_u; end
            OPC_JAL:   begin legal = 1'b1; rd_we = 1'b1; res = pc4; npc = pc + imm_j; end
            OPC_JALR: begin
                legal = (f3 == 3'b000);
                rd_we = 1'b1;
                res   = pc4;
                if (legal) npc = (rs1_val + imm_i) & ~64'h1;
            end
            OPC_BRANCH: begin
                legal = 1'b1;
                res   = rs1_val - rs2_val;
                case (f3)
                    3'b000: if (rs1_val == rs2_val) npc = pc + imm_b;
                    3'b001: if (rs1_val != rs2_val) npc = pc + imm_b;
                    3'b100: if ($signed(rs1_val) <  $signed(rs2_val)) npc = pc + imm_b;
                    3'b101: if ($signed(rs1_val) >= $signed(rs2_val)) npc = pc + imm_b;
                    3'b110: if (rs1_val <  rs2_val) npc = pc + imm_b;
                    3'b111: if (rs1_val >= rs2_val) npc = pc + imm_b;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal   = (f3 != 3'b111);
                is_load = 1'b1;
                rd_we   = 1'b1;
                res     = rs1_val + imm_i;
            end
            OPC_STORE: begin
                legal    = ~f3[2];
                is_store = 1'b1;
                res      = rs1_val + imm_s;
            end
            OPC_OPIMM: begin
                rd_we = 1'b1;
                if (f3 == 3'b001)      legal = (inst[31:26] == 6'b000000);
                else if (f3 == 3'b101) legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
                else                   legal = 1'b1;
                res = alu_f((f3 == 3'b101) && inst[30], f3, rs1_val, imm_i, 1'b0);
            end
            OPC_OPIMM32: begin
                rd_we = 1'b1;
                if (f3 == 3'b000)      legal = 1'b1;
                else if (f3 == 3'b001) legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                res = alu_f((f3 == 3'b101) && inst[30], f3, rs1_val, imm_i, 1'b1);
            end
            OPC_OP: begin
                rd_we = 1'b1;
                legal = 1'b1;
                if (f7 == 7'b0000000)
                    res = alu_f(1'b0, f3, rs1_val, rs2_val, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    res = alu_f(1'b1, f3, rs1_val, rs2_val, 1'b0);
`ifdef RV64M_EN
                else if (f7 == 7'b0000001)
                    res = mdu_f(f3, rs1_val, rs2_val, 1'b0);
`endif
                else
                    legal = 1'b0;
            end
            OPC_OP32: begin
                rd_we = 1'b1;
                legal = 1'b1;
                if (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101))
                    res = alu_f(1'b0, f3, rs1_val, rs2_val, 1'b1);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    res = alu_f(1'b1, f3, rs1_val, rs2_val, 1'b1);
`ifdef RV64M_EN
                else if (f7 == 7'b0000001 && (f3 == 3'b000 || f3[2]))
                    res = mdu_f(f3, rs1_val, rs2_val, 1'b1);
`endif
                else
                    legal = 1'b0;
            end
            default: begin
                legal     = (inst == INST_EBREAK);
                is_ebreak = (inst == INST_EBREAK);
            end
        endcase
        if (!legal) npc = pc4;
    end

    logic [63:0]     ea, mem_off, ld_raw, ld_data, st_data, wb;
    logic [IDXW-1:0] mem_idx;
    logic [7:0]      st_mask;
    logic            in_range, misal, ld_en, st_en, st_we, rf_we;

    assign ea       = res;
    assign mem_off  = ea - DMEM_BASE;
    assign mem_idx  = mem_off[IDXW+2:3];
    assign in_range = (mem_off < DMEM_BYTES);
    assign ld_en    = legal && is_load;
    assign st_en    = legal && is_store;

    // Alignment, load lane extraction and store lane generation.
    always_comb begin
        case (f3[1:0])
            2'b00:   begin misal = 1'b0;        st_mask = 8'h01; end
            2'b01:   begin misal = ea[0];       st_mask = 8'h03; end
            2'b10:   begin misal = |ea[1:0];    st_mask = 8'h0F; end
            default: begin misal = |ea[2:0];    st_mask = 8'hFF; end
        endcase
        st_mask   = st_mask << ea[2:0];
        st_data   = rs2_val << {ea[2:0], 3'b000};
        mem_fault = (ld_en || st_en) && (!in_range || misal);
        ld_raw    = mem_q[mem_idx] >> {ea[2:0], 3'b000};
        case (f3)
            3'b000:  ld_data = {{56{ld_raw[7]}},  ld_raw[7:0]};
            3'b001:  ld_data = {{48{ld_raw[15]}}, ld_raw[15:0]};
            3'b010:  ld_data = {{32{ld_raw[31]}}, ld_raw[31:0]};
            3'b011:  ld_data = ld_raw;
            3'b100:  ld_data = {56'b0, ld_raw[7:0]};
            3'b101:  ld_data = {48'b0, ld_raw[15:0]};
            3'b110:  ld_data = {32'b0, ld_raw[31:0]};
            default: ld_data = '0;
        endcase
        if (mem_fault) ld_data = '0;
    end

    assign wb         = ld_en ? ld_data : res;
    assign rf_we      = legal && rd_we && (rd != 5'd0);
    assign st_we      = st_en && !mem_fault;
    assign nextpc     = npc;
    assign alu_result = res;
    assign ebreak     = is_ebreak;
    assign illegal    = !legal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rd] <= wb;
        end
    end

    // Data RAM keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (rst && st_we) begin
            for (int b = 0; b < 8; b++)
                if (st_mask[b]) mem_q[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_rv64_decode_exec_mem.sv
// Directed-vector bench for rv64_decode_exec_mem with a queue scoreboard and negedge monitor.
module tb_rv64_decode_exec_mem;

    logic        clk, rst;
    logic [63:0] pc, nextpc, alu_result, dbg_rdata;
    logic [31:0] inst;
    logic        ebreak, illegal, mem_fault;
    logic [4:0]  dbg_raddr;

    rv64_decode_exec_mem dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .nextpc(nextpc),
        .alu_result(alu_result), .ebreak(ebreak), .illegal(illegal),
        .mem_fault(mem_fault), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] npc;
        logic [2:0]  fl;
        logic [63:0] dbg;
        logic        chk_alu;
        logic [63:0] alu;
    } exp_t;

    localparam logic [2:0]  F_NONE = 3'b000, F_EBR = 3'b100, F_ILL = 3'b010, F_FLT = 3'b001;
    localparam logic [63:0] M5  = 64'hFFFF_FFFF_FFFF_FFFB;
    localparam logic [63:0] UPX = 64'hFFFF_FFFF_8000_0000;
`ifdef RV64M_EN
    localparam bit M_ON = 1'b1;
`else
    localparam bit M_ON = 1'b0;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic vld = 1'b0;
    logic drain_req = 1'b0;
    logic drain_done = 1'b0;

    function automatic logic [31:0] enc_i(input int imm, input int r1, input int f3, input int rd, input int op);
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int r2, input int r1, input int f3);
        return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int r2, input int r1, input int f3);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int r2, input int r1, input int f3, input int rd, input int op);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    task automatic step(input string nm, input logic r, input logic [63:0] p, input logic [31:0] in,
                        input logic [4:0] da, input logic [63:0] e_npc, input logic [2:0] e_fl,
                        input logic [63:0] e_dbg, input logic ca, input logic [63:0] e_alu);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; pc = p; inst = in; dbg_raddr = da; vld = 1'b1;
        e.name = nm; e.npc = e_npc; e.fl = e_fl; e.dbg = e_dbg; e.chk_alu = ca; e.alu = e_alu;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (vld) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got=empty exp=entry");
            end else begin
                mon_e = sb_q.pop_front();
                cmp(mon_e.name, "nextpc", nextpc, mon_e.npc);
                cmp(mon_e.name, "flags", {61'b0, ebreak, illegal, mem_fault}, {61'b0, mon_e.fl});
                cmp(mon_e.name, "dbg", dbg_rdata, mon_e.dbg);
                if (mon_e.chk_alu) cmp(mon_e.name, "alu", alu_result, mon_e.alu);
            end
        end
        if (drain_req && !drain_done) begin
            cmp("drain", "pending", 64'(sb_q.size()), 64'd0);
            drain_done = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; pc = '0; inst = 32'h0000_0013; dbg_raddr = '0;
        repeat (3) @(posedge clk);
        step("addi_neg", 1, 64'h1000, enc_i(-5, 0, 0, 1, 7'h13),  0, 64'h1004, F_NONE, 0,    1, M5);
        step("lui",      1, 64'h1000, enc_u(32'h80000, 2, 7'h37), 1, 64'h1004, F_NONE, M5,   1, UPX);
        step("addiw",    1, 64'h1000, enc_i(0, 2, 0, 3, 7'h1B),   2, 64'h1004, F_NONE, UPX,  1, UPX);
        step("addi_one", 1, 64'h1000, enc_i(1, 0, 0, 8, 7'h13),   3, 64'h1004, F_NONE, UPX,  1, 64'h1);
        step("slli",     1, 64'h1000, enc_i(31, 8, 1, 8, 7'h13),  8, 64'h1004, F_NONE, 64'h1, 1, 64'h8000_0000);
        step("sd",       1, 64'h1000, enc_s(8, 1, 8, 3),          8, 64'h1004, F_NONE, 64'h8000_0000, 1, 64'h8000_0008);
        step("lbu",      1, 64'h1000, enc_i(9, 8, 4, 4, 7'h03),   0, 64'h1004, F_NONE, 0,    1, 64'h8000_0009);
        step("lb",       1, 64'h1000, enc_i(8, 8, 0, 5, 7'h03),   4, 64'h1004, F_NONE, 64'hFF, 1, 64'h8000_0008);
        step("addi_x6",  1, 64'h1000, enc_i(1, 0, 0, 6, 7'h13),   5, 64'h1004, F_NONE, M5,   1, 64'h1);
        step("sd_misal", 1, 64'h1000, enc_s(11, 6, 8, 3),         6, 64'h1004, F_FLT,  64'h1, 1, 64'h8000_000B);
        step("ld",       1, 64'h1000, enc_i(8, 8, 3, 9, 7'h03),   0, 64'h1004, F_NONE, 0,    1, 64'h8000_0008);
        step("bltu_nt",  1, 64'h8000_0010, enc_b(-16, 6, 1, 6),   9, 64'h8000_0014, F_NONE, M5, 0, 0);
        step("blt_t",    1, 64'h8000_0010, enc_b(-16, 6, 1, 4),   0, 64'h8000_0000, F_NONE, 0,  0, 0);
        step("addi_x10", 1, 64'h1000, enc_i(256, 8, 0, 10, 7'h13), 0, 64'h1004, F_NONE, 0,   1, 64'h8000_0100);
        step("jalr",     1, 64'h2000, enc_i(3, 10, 0, 7, 7'h67),  10, 64'h8000_0102, F_NONE, 64'h8000_0100, 1, 64'h2004);
        step("wr_x0",    1, 64'h1000, enc_i(5, 0, 0, 0, 7'h13),   7, 64'h1004, F_NONE, 64'h2004, 1, 64'h5);
        step("ebreak",   1, 64'h1000, 32'h0010_0073,              0, 64'h1004, F_EBR,  0,    0, 0);
        step("div0",     1, 64'h1000, enc_r(1, 0, 1, 4, 9, 7'h33), 0, 64'h1004, M_ON ? F_NONE : F_ILL, 0, M_ON, '1);
        step("rem0",     1, 64'h1000, enc_r(1, 0, 1, 6, 4, 7'h33), 9, 64'h1004, M_ON ? F_NONE : F_ILL,
             M_ON ? 64'hFFFF_FFFF_FFFF_FFFF : M5, M_ON, M5);
        step("subw",     1, 64'h1000, enc_r(32, 6, 2, 0, 13, 7'h3B), 4, 64'h1004, F_NONE, M_ON ? M5 : 64'hFF, 1, 64'h7FFF_FFFF);
        step("srai",     1, 64'h1000, enc_i(32'h401, 1, 5, 14, 7'h13), 13, 64'h1004, F_NONE, 64'h7FFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFD);
        step("sraiw",    1, 64'h1000, enc_i(32'h404, 2, 5, 15, 7'h1B), 14, 64'h1004, F_NONE, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_F800_0000);
        step("sltu",     1, 64'h1000, enc_r(0, 1, 6, 3, 16, 7'h33), 15, 64'h1004, F_NONE, 64'hFFFF_FFFF_F800_0000, 1, 64'h1);
        step("auipc",    1, 64'h3000, enc_u(1, 17, 7'h17),        16, 64'h3004, F_NONE, 64'h1, 1, 64'h4000);
        step("jal",      1, 64'h3000, enc_j(-8, 18),              17, 64'h2FF8, F_NONE, 64'h4000, 1, 64'h3004);
        step("lh_misal", 1, 64'h1000, enc_i(9, 8, 1, 19, 7'h03),  18, 64'h1004, F_FLT,  64'h3004, 1, 64'h8000_0009);
        step("ld_below", 1, 64'h1000, enc_i(-8, 8, 3, 20, 7'h03), 19, 64'h1004, F_FLT,  0,    1, 64'h7FFF_FFF8);
        step("lui_x21",  1, 64'h1000, enc_u(1, 21, 7'h37),        20, 64'h1004, F_NONE, 0,    1, 64'h1000);
        step("add_x21",  1, 64'h1000, enc_r(0, 8, 21, 0, 21, 7'h33), 21, 64'h1004, F_NONE, 64'h1000, 1, 64'h8000_1000);
        step("ld_top",   1, 64'h1000, enc_i(-8, 21, 3, 22, 7'h03), 21, 64'h1004, F_NONE, 64'h8000_1000, 1, 64'h8000_0FF8);
        step("ld_end",   1, 64'h1000, enc_i(0, 21, 3, 22, 7'h03), 0, 64'h1004, F_FLT,  0,    1, 64'h8000_1000);
        step("rst_sd",   0, 64'h1000, enc_s(8, 6, 8, 3),          22, 64'h1004, F_NONE, 0,    1, 64'h8000_0008);
        step("rst_x1",   1, 64'h1000, enc_i(1, 0, 0, 8, 7'h13),   1, 64'h1004, F_NONE, 0,    1, 64'h1);
        step("slli2",    1, 64'h1000, enc_i(31, 8, 1, 8, 7'h13),  6, 64'h1004, F_NONE, 0,    1, 64'h8000_0000);
        step("ld_keep",  1, 64'h1000, enc_i(8, 8, 3, 24, 7'h03),  8, 64'h1004, F_NONE, 64'h8000_0000, 1, 64'h8000_0008);
        step("ram_kept", 1, 64'h1000, 32'h0000_0013,              24, 64'h1004, F_NONE, M5,  1, 64'h0);
        @(posedge clk);
        #1;
        vld = 1'b0;
        drain_req = 1'b1;
        for (int i = 0; i < 8 && !drain_done; i++) @(negedge clk);
        #1;
        if (!drain_done) begin
            $display("FAIL drain got=stalled exp=done");
            $fatal(1, "monitor stalled");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
